// File: rtl/j1_io_pkg.sv
// j1_io_pkg: register offsets, STATUS bit indices and UART FSM state
// encodings shared by the J1 IO peripherals.
package j1_io_pkg;

  localparam logic [31:0] REG_DATA_OFS   = 32'h0;
  localparam logic [31:0] REG_STATUS_OFS = 32'h4;
  localparam logic [31:0] REG_CTRL_OFS   = 32'h8;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_RX_VALID   = 1;
  localparam int ST_TX_EMPTY   = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_FRAME_ERR  = 4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/j1_uart_if.sv
// j1_uart_if: J1 CPU IO bus as seen by a memory-mapped peripheral.
// The core is the master; io_din is answered in the same cycle.
interface j1_uart_if;

  logic        io_rd;
  logic        io_wr;
  logic [31:0] io_addr;
  logic [31:0] io_dout;
  logic [31:0] io_din;

  modport master (
    output io_rd,
    output io_wr,
    output io_addr,
    output io_dout,
    input  io_din
  );

  modport slave (
    input  io_rd,
    input  io_wr,
    input  io_addr,
    input  io_dout,
    output io_din
  );

endinterface

// File: rtl/j1_uart_fifo.sv
// j1_uart_fifo: synchronous FIFO with wrap-bit pointers and a
// combinational head; a pop frees room for a same-cycle push.
module j1_uart_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic [W-1:0] mem_q [2**AW];
  logic         do_push;
  logic         do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/j1_uart.sv
// j1_uart: 8N1 UART on the J1 IO bus (DATA, STATUS, optional CTRL).
// Define J1_UART_LOOPBACK_EN to add the CTRL register and TX->RX loopback.
module j1_uart
  import j1_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_8000,
  parameter int          CLK_DIV   = 434,
  parameter int          FIFO_AW   = 4
) (
  input  logic sys_clk_i,
  input  logic sys_rst_i,
  j1_uart_if.slave bus,
  input  logic uart_rx,
  output logic uart_tx
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

  logic hit_data, hit_status;
  logic data_rd, data_wr, stat_rd;

  logic       txf_push, txf_pop, txf_full, txf_empty;
  logic [7:0] txf_head;
  logic       rxf_push, rxf_pop, rxf_full, rxf_empty;
  logic [7:0] rxf_head, rx_byte;

  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          tx_line;

  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic [1:0]    rx_sync_q, rx_sync_d;
  logic          rx_src, rx_s;

  logic ovr_q, ovr_d, ovr_set;
  logic frm_q, frm_d, frm_set;

  logic [31:0] status;
  logic [31:0] din;
  logic        unused_dout;

  assign hit_data   = (bus.io_addr == BASE_ADDR + REG_DATA_OFS);
  assign hit_status = (bus.io_addr == BASE_ADDR + REG_STATUS_OFS);
  assign data_rd    = bus.io_rd && hit_data;
  assign data_wr    = bus.io_wr && hit_data;
  assign stat_rd    = bus.io_rd && hit_status;

  assign txf_push    = data_wr;
  assign rxf_pop     = data_rd && !rxf_empty;
  assign unused_dout = ^bus.io_dout[31:8];

  j1_uart_fifo #(.W(8), .AW(FIFO_AW)) u_txf (
    .clk_i   (sys_clk_i),
    .rst_i   (sys_rst_i),
    .push_i  (txf_push),
    .din_i   (bus.io_dout[7:0]),
    .pop_i   (txf_pop),
    .full_o  (txf_full),
    .empty_o (txf_empty),
    .head_o  (txf_head)
  );

  j1_uart_fifo #(.W(8), .AW(FIFO_AW)) u_rxf (
    .clk_i   (sys_clk_i),
    .rst_i   (sys_rst_i),
    .push_i  (rxf_push),
    .din_i   (rx_byte),
    .pop_i   (rxf_pop),
    .full_o  (rxf_full),
    .empty_o (rxf_empty),
    .head_o  (rxf_head)
  );

`ifdef J1_UART_LOOPBACK_EN
  logic hit_ctrl;
  logic loop_q, loop_d;

  assign hit_ctrl = (bus.io_addr == BASE_ADDR + REG_CTRL_OFS);

  always_comb begin
    loop_d = loop_q;
    if (bus.io_wr && hit_ctrl) loop_d = bus.io_dout[0];
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) loop_q <= 1'b0;
    else           loop_q <= loop_d;
  end

  assign rx_src  = loop_q ? tx_line : uart_rx;
  assign uart_tx = loop_q | tx_line;
`else
  assign rx_src  = uart_rx;
  assign uart_tx = tx_line;
`endif

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    txf_pop    = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (!txf_empty) begin
          txf_pop    = 1'b1;
          tx_sh_d    = txf_head;
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        tx_cnt_d = tx_cnt_q + 1'b1;
        if (tx_cnt_q == DIV_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_cnt_d = tx_cnt_q + 1'b1;
        if (tx_cnt_q == DIV_LAST) begin
          tx_cnt_d = '0;
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          tx_bit_d = tx_bit_q + 1'b1;
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        tx_cnt_d = tx_cnt_q + 1'b1;
        if (tx_cnt_q == DIV_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
          // back-to-back frames skip IDLE
          if (!txf_empty) begin
            txf_pop    = 1'b1;
            tx_sh_d    = txf_head;
            tx_state_d = TX_START;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_line = 1'b1;
    if (tx_state_q == TX_START) tx_line = 1'b0;
    if (tx_state_q == TX_DATA)  tx_line = tx_sh_q[0];
  end

  assign rx_sync_d = {rx_sync_q[0], rx_src};
  assign rx_s      = rx_sync_q[1];
  assign rx_byte   = rx_sh_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rxf_push   = 1'b0;
    ovr_set    = 1'b0;
    frm_set    = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (!rx_s)                     frm_set  = 1'b1;
          else if (rxf_full && !rxf_pop) ovr_set  = 1'b1;
          else                           rxf_push = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // a flag raised in the same cycle as the clearing read survives
  assign ovr_d = (ovr_q && !stat_rd) || ovr_set;
  assign frm_d = (frm_q && !stat_rd) || frm_set;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_sync_q  <= 2'b11;
      ovr_q      <= 1'b0;
      frm_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_sync_q  <= rx_sync_d;
      ovr_q      <= ovr_d;
      frm_q      <= frm_d;
    end
  end

  always_comb begin
    status                = '0;
    status[ST_TX_FULL]    = txf_full;
    status[ST_RX_VALID]   = !rxf_empty;
    status[ST_TX_EMPTY]   = txf_empty && (tx_state_q == TX_IDLE);
    status[ST_RX_OVERRUN] = ovr_q;
    status[ST_FRAME_ERR]  = frm_q;
  end

  always_comb begin
    din = '0;
    if (bus.io_rd) begin
      unique case (1'b1)
        hit_data:   din = {24'b0, rxf_empty ? 8'h00 : rxf_head};
        hit_status: din = status;
`ifdef J1_UART_LOOPBACK_EN
        hit_ctrl:   din = {31'b0, loop_q};
`endif
        default:    din = '0;
      endcase
    end
  end

  assign bus.io_din = din;

endmodule
